// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and types for the PWM generator.
// Center-aligned counting is enabled with the PWM_CENTER_ALIGN_EN macro.
package pwm_pkg;

  // Default configuration: 100 ticks per period, 10-tick duty steps.
  localparam int CNT_W_DEF      = 8;
  localparam int PERIOD_DEF     = 100;
  localparam int STEP_DEF       = 10;
  localparam int RESET_DUTY_DEF = 50;

  // Largest meaningful duty value: output high for the whole period.
  localparam int DUTY_MAX       = PERIOD_DEF;

  // Duty / counter word at the default width.
  typedef logic [CNT_W_DEF-1:0] duty_t;

  // Counting direction of the triangle counter (center-aligned build only).
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_tick_sync.sv
// pwm_tick_sync: brings the divided clock into the Clock_in domain as data
// and turns each of its rising edges into a single-cycle tick enable.
// The tick follows a Clock_div rising edge by 2-3 Clock_in cycles.
module pwm_tick_sync
  import pwm_pkg::*;
(
  input  logic Clock_in,
  input  logic Reset,
  input  logic Clock_div,
  output logic tick
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two-flop synchronizer followed by a history flop for edge detection
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Clock_div;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Rising edge of the synchronized divided clock, one Clock_in cycle wide
  assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: duty-cycle counter and glitch-free PWM output driven by the
// divided clock used as a rate enable. Duty requests update a pending
// register every cycle; the active duty only changes at a period boundary,
// so the output never produces runt pulses.
// Optional: define PWM_CENTER_ALIGN_EN for a triangle (center-aligned)
// counter with a 2*PERIOD tick period; the default build is edge-aligned.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PERIOD     = PERIOD_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int RESET_DUTY = RESET_DUTY_DEF
) (
  input  logic             Clock_in,
  input  logic             Reset,
  input  logic             Clock_div,
  input  logic             Duty_up,
  input  logic             Duty_down,
  input  logic             Duty_load,
  input  logic [CNT_W-1:0] Duty_value,
  output logic             Pwm_out,
  output logic [CNT_W-1:0] Duty_current,
  output logic             Period_start
);

  // Constants at the widths they are compared against.
  localparam logic [CNT_W:0]   PERIOD_X     = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X       = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_TOP     = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] DUTY_AT_RST  = CNT_W'(RESET_DUTY);

  // Add one step, saturating at a full-period duty.
  function automatic logic [CNT_W-1:0] sat_up(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] sum;
    sum = {1'b0, d} + STEP_X;
    return (sum > PERIOD_X) ? DUTY_TOP : sum[CNT_W-1:0];
  endfunction

  // Subtract one step, saturating at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_down(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] diff;
    diff = {1'b0, d} - STEP_X;
    return ({1'b0, d} < STEP_X) ? '0 : diff[CNT_W-1:0];
  endfunction

  // Clamp a directly loaded duty to the period length.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
    return ({1'b0, v} > PERIOD_X) ? DUTY_TOP : v;
  endfunction

  logic             tick;
  logic             wrap;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [CNT_W-1:0] duty_pending_q, duty_pending_d;
  logic [CNT_W-1:0] duty_active_q,  duty_active_d;
  logic             pwm_q,          pwm_d;
  logic             period_start_q;

  pwm_tick_sync u_tick_sync (
    .Clock_in  (Clock_in),
    .Reset     (Reset),
    .Clock_div (Clock_div),
    .tick      (tick)
  );

`ifdef PWM_CENTER_ALIGN_EN
  dir_e dir_q, dir_d;

  // Triangle counter: holds for one tick at each end while direction flips
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (tick) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q == CNT_LAST) begin
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d = DIR_UP;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Counter and direction state
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // High while the counter is above PERIOD-duty: pulse centred on the peak
  always_comb begin
    pwm_d = ({1'b0, cnt_q} >= (PERIOD_X - {1'b0, duty_active_q}));
  end
`else
  // Edge-aligned sawtooth counter advancing once per tick
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter state
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High for the first duty ticks of each period
  always_comb begin
    pwm_d = (cnt_q < duty_active_q);
  end
`endif

  // Pending duty: load beats step; simultaneous up and down cancel out
  always_comb begin
    duty_pending_d = duty_pending_q;
    if (Duty_load) begin
      duty_pending_d = clamp_load(Duty_value);
    end else if (Duty_up && !Duty_down) begin
      duty_pending_d = sat_up(duty_pending_q);
    end else if (Duty_down && !Duty_up) begin
      duty_pending_d = sat_down(duty_pending_q);
    end
  end

  // Active duty takes the pre-update pending value on the boundary tick
  always_comb begin
    duty_active_d = wrap ? duty_pending_q : duty_active_q;
  end

  // Duty registers
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      duty_pending_q <= DUTY_AT_RST;
      duty_active_q  <= DUTY_AT_RST;
    end else begin
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
    end
  end

  // Registered outputs: PWM compare result and period boundary pulse
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pwm_q          <= pwm_d;
      period_start_q <= wrap;
    end
  end

  assign Pwm_out      = pwm_q;
  assign Period_start = period_start_q;
  assign Duty_current = duty_active_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed bench for pwm_generator at default parameters.
// Clock_div toggles every 4 Clock_in cycles, giving one tick per 8 cycles.
// Honours PWM_CENTER_ALIGN_EN for the expected period and high times.
`timescale 1ns/1ps
module tb_pwm_generator;

  localparam int CYC_PER_TICK = 8;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int TICKS_PER_PERIOD = 200;
  localparam int HIGH_MUL         = 2;
`else
  localparam int TICKS_PER_PERIOD = 100;
  localparam int HIGH_MUL         = 1;
`endif
  localparam int PER_CYC    = TICKS_PER_PERIOD * CYC_PER_TICK;
  localparam int WAIT_LIMIT = 2 * PER_CYC + 64;

  logic       Clock_in = 1'b0;
  logic       Reset;
  logic       Clock_div;
  logic       Duty_up;
  logic       Duty_down;
  logic       Duty_load;
  logic [7:0] Duty_value;
  logic       Pwm_out;
  logic [7:0] Duty_current;
  logic       Period_start;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_generator dut (
    .Clock_in     (Clock_in),
    .Reset        (Reset),
    .Clock_div    (Clock_div),
    .Duty_up      (Duty_up),
    .Duty_down    (Duty_down),
    .Duty_load    (Duty_load),
    .Duty_value   (Duty_value),
    .Pwm_out      (Pwm_out),
    .Duty_current (Duty_current),
    .Period_start (Period_start)
  );

  always #5 Clock_in = ~Clock_in;

  initial begin
    Clock_div = 1'b0;
    forever begin
      repeat (4) @(negedge Clock_in);
      Clock_div = ~Clock_div;
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle request pulse, driven from a falling edge
  task automatic pulse(input bit up, input bit dn, input bit ld, input logic [7:0] val);
    Duty_up    = up;
    Duty_down  = dn;
    Duty_load  = ld;
    Duty_value = val;
    @(negedge Clock_in);
    Duty_up   = 1'b0;
    Duty_down = 1'b0;
    Duty_load = 1'b0;
  endtask

  // Skip to the next boundary, then count cycles and high cycles up to the one after
  task automatic measure(output int len, output int highs, output logic [7:0] duty0,
                         output bit ok);
    int w;
    w     = 0;
    ok    = 1'b1;
    len   = 0;
    highs = 0;
    duty0 = '0;
    do begin
      @(negedge Clock_in);
      w++;
    end while (Period_start !== 1'b1 && w < WAIT_LIMIT);
    if (Period_start !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    duty0 = Duty_current;
    do begin
      if (Pwm_out === 1'b1) highs++;
      len++;
      @(negedge Clock_in);
    end while (Period_start !== 1'b1 && len < WAIT_LIMIT);
    if (Period_start !== 1'b1) ok = 1'b0;
  endtask

  task automatic period_check(input string tag, input int exp_duty, input int exp_high,
                              input bit chk_high);
    int         len;
    int         highs;
    logic [7:0] duty0;
    bit         ok;
    measure(len, highs, duty0, ok);
    check({tag, "_bounded"}, ok, 1);
    check({tag, "_duty"}, duty0, exp_duty);
    check({tag, "_len"}, len, PER_CYC);
    if (chk_high) check({tag, "_high"}, highs, exp_high);
  endtask

  initial begin
    int  w;
    bit  in_range;

    Reset      = 1'b1;
    Duty_up    = 1'b0;
    Duty_down  = 1'b0;
    Duty_load  = 1'b0;
    Duty_value = '0;
    repeat (3) @(negedge Clock_in);
    check("rst_pwm",    Pwm_out,      0);
    check("rst_pstart", Period_start, 0);
    check("rst_duty",   Duty_current, 50);
    Reset = 1'b0;

    // Reset duty: 50 ticks high per period
    period_check("base", 50, 50 * CYC_PER_TICK * HIGH_MUL, 1'b1);

    // Three steps up mid-period stay pending until the boundary
    repeat (200) @(negedge Clock_in);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge Clock_in);
    end
    check("up_hold", Duty_current, 50);
    period_check("up3", 80, 80 * CYC_PER_TICK * HIGH_MUL, 1'b1);

    // Oversized load clamps to a full-period duty
    repeat (100) @(negedge Clock_in);
    pulse(1'b0, 1'b0, 1'b1, 8'd200);
    check("load_hold", Duty_current, 80);
    period_check("load_clamp", 100, 0, 1'b0);
    period_check("full", 100, PER_CYC, 1'b1);

    // Eleven steps down saturate at zero
    repeat (50) @(negedge Clock_in);
    for (int i = 0; i < 11; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge Clock_in);
    end
    period_check("down_sat", 0, 0, 1'b0);
    period_check("zero", 0, 0, 1'b1);

    // Up with down cancels; load with up takes the loaded value
    repeat (30) @(negedge Clock_in);
    pulse(1'b1, 1'b1, 1'b0, 8'd0);
    period_check("updn", 0, 0, 1'b1);
    repeat (30) @(negedge Clock_in);
    pulse(1'b1, 1'b0, 1'b1, 8'd30);
    period_check("ld_up", 30, 30 * CYC_PER_TICK * HIGH_MUL, 1'b1);

    // Step request on the boundary tick itself lands one period later
    repeat (PER_CYC - 1) @(negedge Clock_in);
    pulse(1'b1, 1'b0, 1'b0, 8'd0);
    check("coinc_edge", Period_start, 1);
    check("coinc_duty", Duty_current, 30);
    period_check("coinc_next", 40, 40 * CYC_PER_TICK * HIGH_MUL, 1'b1);

    // Reset mid-period with a load still pending
    pulse(1'b0, 1'b0, 1'b1, 8'd90);
    repeat (37 * CYC_PER_TICK + 3) @(negedge Clock_in);
    #2 Reset = 1'b1;
    #1;
    check("arst_pwm",    Pwm_out,      0);
    check("arst_duty",   Duty_current, 50);
    check("arst_pstart", Period_start, 0);
    repeat (3) @(negedge Clock_in);
    Reset = 1'b0;
    w = 0;
    do begin
      @(negedge Clock_in);
      w++;
    end while (Period_start !== 1'b1 && w < WAIT_LIMIT);
    in_range = (w >= PER_CYC - 10) && (w <= PER_CYC + 2);
    check("restart_cycles", in_range, 1);
    check("restart_duty", Duty_current, 50);
    period_check("post_rst", 50, 50 * CYC_PER_TICK * HIGH_MUL, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
Digital PWM stage directly downstream of the frequency divider. Consumes the divided clock (about 1.56 kHz from the 100 MHz board clock) as a rate enable, not as a clock. It runs a duty-cycle counter in the Clock_in domain and drives a glitch-free PWM output. Duty is adjusted by step pulses or a direct load, and applied only at period boundaries.

Parameters:
CNT_W, 8, counter and duty width; must satisfy 2^CNT_W > PERIOD
PERIOD, 100, ticks per PWM period (edge-aligned); duty is expressed in ticks, 0..PERIOD
STEP, 10, duty increment/decrement per Duty_up/Duty_down pulse
RESET_DUTY, 50, duty value after reset; must be <= PERIOD

Ports:
Clock_in  input  1  system clock, 100 MHz
Reset  input  1  asynchronous, active-high reset
Clock_div  input  1  divided clock from the divider; treated as asynchronous data
Duty_up  input  1  single-cycle pulse, Clock_in domain: add STEP to pending duty
Duty_down  input  1  single-cycle pulse: subtract STEP from pending duty
Duty_load  input  1  single-cycle pulse: pending duty <= Duty_value
Duty_value  input  CNT_W  direct duty value, sampled when Duty_load=1
Pwm_out  output  1  registered PWM output
Duty_current  output  CNT_W  duty value currently in effect (active register)
Period_start  output  1  one-cycle pulse at each period boundary

Behaviour:
- Reset is asynchronous, active-high. All flops clear immediately.
  - Counter cnt=0; sync flops=0; Pwm_out=0; Period_start=0.
  - duty_pending = duty_active = RESET_DUTY; Duty_current = RESET_DUTY.
  - A reset mid-period abandons the period; no partial update survives.
- Tick generation:
  - Clock_div passes through a 2-flop synchronizer, then a third flop.
  - tick = s2 & ~s3, exactly one Clock_in cycle wide.
  - tick appears 2-3 cycles after the Clock_div rising edge; there is one tick per Clock_div period.
- Counter (edge-aligned):
  - cnt advances only on tick: cnt==PERIOD-1 -> 0, else cnt+1.
  - On that wrap tick, duty_active <= duty_pending and Period_start <= 1 for one cycle.
- Pending duty (every cycle, independent of tick):
  - Priority: Duty_load > (Duty_up xor Duty_down). Duty_up and Duty_down together -> no change.
  - Up: min(duty_pending+STEP, PERIOD). Down: max(duty_pending-STEP, 0), with no underflow wrap.
  - Load: min(Duty_value, PERIOD).
  - Use CNT_W+1 intermediate width for the arithmetic.
  - If a pending update coincides with the wrap tick, the old duty_pending is transferred; the new value applies at the next wrap.
- Output:
  - Pwm_out <= (cnt < duty_active), registered, one Clock_in cycle after cnt/duty change.
  - Duty 0 -> Pwm_out constant 0. Duty PERIOD -> constant 1. No runt pulses, since duty changes only at wrap.
- Duty_current = duty_active, registered.

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- Defined: triangle counter 0,1,..,PERIOD-1,PERIOD-1,..,1,0,0,1,..
  - A direction flop flips at each endpoint tick, and the counter holds its value for that tick.
  - Period = 2*PERIOD ticks.
  - Pwm_out <= (cnt >= PERIOD-duty_active): a pulse of 2*duty ticks centred on the peak.
  - Duty transfer and Period_start occur only on the tick where cnt==0 and direction is down.
  - Reset sets direction to up.
- Undefined: edge-aligned behaviour as above; no direction flop exists.

Decomposition:
- Package pwm_pkg:
  - CNT_W, PERIOD, STEP, RESET_DUTY defaults.
  - Duty type logic [CNT_W-1:0].
  - Constant DUTY_MAX = PERIOD.
- One sub-module: pwm_tick_sync.
  - Contents: 2-flop synchronizer, edge flop, tick output.
  - Ports: Clock_in, Reset, Clock_div, tick.
- Counter, duty registers and compare stay in pwm_generator.

Test Plan:
Defaults throughout; Clock_div toggles every 4 Clock_in cycles (tick every 8 cycles).
- Reset released, no duty input -> Duty_current=50; Pwm_out high for 50 ticks (400 cycles) and low for 50 ticks per 100-tick period; Period_start every 800 cycles.
- 3 Duty_up pulses mid-period -> Duty_current stays 50 until the next Period_start, then becomes 80; high time 640 cycles.
- Duty_load with Duty_value=200 -> clamped to 100, Pwm_out constant 1 after the wrap. Then 11 Duty_down pulses -> 0, Pwm_out constant 0 with no glitch.
- Duty_up and Duty_down in the same cycle -> no change. Duty_load with Duty_up in the same cycle -> loaded value wins.
- Reset asserted mid-period at cnt=37 -> all outputs take reset values asynchronously; counting restarts from 0 after release.
- With PWM_CENTER_ALIGN_EN, duty 30 -> period 200 ticks; Pwm_out high for ticks with cnt>=70, 60 ticks centred on the peak; Period_start once per 200 ticks.
